// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM state
// encoding and default widths / halt encoding.
package fetch_pkg;

    localparam int          AW_DEF        = 5;
    localparam int          DW_DEF        = 32;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_out_slot.sv
// Valid/ready output register toward decode. Holds one fetched word and
// its address. A load always wins over a flush; otherwise the slot holds.
module fetch_out_slot
    import fetch_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_flush,
    input  logic [DW-1:0] i_instr,
    input  logic [AW-1:0] i_pc,
    output logic          o_valid,
    output logic [DW-1:0] o_instr,
    output logic [AW-1:0] o_pc
);

    // Capture a new word, drop the current one, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_instr <= '0;
            o_pc    <= '0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_instr <= i_instr;
            o_pc    <= i_pc;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the combinational
// instruction memory, and registers each word into a valid/ready slot.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start, no fetch
// RUN     | fetching one word per cycle whenever the slot is free
// HALTED  | halt word seen; pending word drains, waits for start/redirect
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int          AW        = AW_DEF,
    parameter int          DW        = DW_DEF,
    parameter int          RESET_PC  = 0,
    parameter logic [DW-1:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] im_addr,
    input  logic [DW-1:0] im_instr,
    output logic          if_valid,
    input  logic          if_ready,
    output logic [DW-1:0] if_instr,
    output logic [AW-1:0] if_pc,
    input  logic          br_valid,
    input  logic [AW-1:0] br_target,
    output logic          halted,
    output logic          busy
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0]   fetch_cnt,
    output logic [31:0]   stall_cnt,
    output logic [15:0]   flush_cnt
`endif
);

    localparam logic [AW-1:0] PC_RST = AW'(RESET_PC);
    localparam logic [AW-1:0] PC_ONE = AW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_nxt;
    logic          w_load;
    logic          w_flush;
    logic          w_slot_free;

    assign w_slot_free = !if_valid || if_ready;
    assign im_addr     = r_pc;
    assign busy        = (r_state == ST_RUN);
    assign halted      = (r_state == ST_HALTED);

    // State and program counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= PC_RST;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Next state, next PC and slot controls; redirect beats start beats fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_pc_nxt    = PC_RST;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (br_valid) begin
                    w_pc_nxt = br_target;
                    w_flush  = 1'b1;
                end else if (w_slot_free) begin
                    w_load = 1'b1;
                    if (im_instr == HALT_WORD) begin
                        w_state_nxt = ST_HALTED;
                    end else begin
                        w_pc_nxt = r_pc + PC_ONE;
                    end
                end
            end
            ST_HALTED: begin
                if (br_valid) begin
                    w_pc_nxt    = br_target;
                    w_flush     = 1'b1;
                    w_state_nxt = ST_RUN;
                end else if (start) begin
                    w_pc_nxt    = PC_RST;
                    w_flush     = 1'b1;
                    w_state_nxt = ST_RUN;
                end else if (if_ready) begin
                    // Decode took the last word; nothing replaces it.
                    w_flush = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    fetch_out_slot #(
        .AW (AW),
        .DW (DW)
    ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_instr (im_instr),
        .i_pc    (r_pc),
        .o_valid (if_valid),
        .o_instr (if_instr),
        .o_pc    (if_pc)
    );

`ifdef FETCH_PERF_CNT_EN
    logic w_stall;
    logic w_br_flush;

    assign w_stall    = (r_state == ST_RUN) && if_valid && !if_ready;
    assign w_br_flush = br_valid && (r_state != ST_IDLE) && if_valid;

    // Saturating event counters; only reset clears them, start does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (w_load && (fetch_cnt != '1))     fetch_cnt <= fetch_cnt + 32'd1;
            if (w_stall && (stall_cnt != '1))    stall_cnt <= stall_cnt + 32'd1;
            if (w_br_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Accepted words are checked against a
// queue of expected {pc, instr} entries pushed as each phase is set up.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  im_addr;
    logic [31:0] im_instr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [4:0]  if_pc;
    logic        br_valid;
    logic [4:0]  br_target;
    logic        halted;
    logic        busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    logic [31:0] mem [32];
    logic [36:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    assign im_instr = mem[im_addr];

    fetch_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .im_addr   (im_addr),
        .im_instr  (im_instr),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .br_valid  (br_valid),
        .br_target (br_target),
        .halted    (halted),
        .busy      (busy)
`ifdef FETCH_PERF_CNT_EN
       ,.fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a);
        exp_q.push_back({a, mem[a]});
    endtask

    // Every handshake (no redirect in the same cycle) must match the queue head.
    always @(negedge clk) begin
        if (rst_n && if_valid && if_ready && !br_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {if_pc, if_instr}, 37'h0);
            end else begin
                chk("accepted_word", {if_pc, if_instr}, exp_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h1111_1111;
        mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333;
        mem[3] = 32'h4444_4444;
        mem[5] = 32'hFFFF_FFFF;

        rst_n = 1'b0; start = 1'b0; if_ready = 1'b0; br_valid = 1'b0; br_target = '0;
        tick(); tick();
        chk("rst_valid",  37'(if_valid), 37'(1'b0));
        chk("rst_addr",   37'(im_addr),  37'(5'd0));
        chk("rst_instr",  37'(if_instr), 37'(32'h0));
        chk("rst_pc",     37'(if_pc),    37'(5'd0));
        chk("rst_flags",  37'({halted, busy}), 37'(2'b00));
        rst_n = 1'b1;
        tick();
        chk("idle_busy",  37'(busy), 37'(1'b0));

        // Sequential fetch 0..5, stall at pc 2, halt on word 5.
        push(5'd0); push(5'd1); push(5'd2); push(5'd3); push(5'd4); push(5'd5);
        start = 1'b1; if_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy",  37'(busy),     37'(1'b1));
        chk("start_valid", 37'(if_valid), 37'(1'b0));
        chk("start_addr",  37'(im_addr),  37'(5'd0));
        for (int a = 0; a < 3; a++) begin
            tick();
            chk("seq_pc",   37'({if_valid, if_pc}), 37'({1'b1, 5'(a)}));
            chk("seq_lead", 37'(im_addr), 37'(5'(a + 1)));
        end
        if_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("stall_pc",    37'({if_valid, if_pc}), 37'({1'b1, 5'd2}));
            chk("stall_instr", 37'(if_instr), 37'(32'h3333_3333));
            chk("stall_addr",  37'(im_addr),  37'(5'd3));
        end
        if_ready = 1'b1;
        tick();
        chk("release_pc", 37'({if_pc, if_instr}), {5'd3, 32'h4444_4444});
        tick();
        chk("pre_halt_pc", 37'(if_pc), 37'(5'd4));
        tick();
        if_ready = 1'b0;
        chk("halt_word",  37'({if_valid, if_pc, if_instr}) , {1'b1, 5'd5, 32'hFFFF_FFFF} & 37'h1F_FFFF_FFFF);
        chk("halt_flags", 37'({halted, busy}), 37'(2'b10));
        tick(); tick();
        chk("halt_hold",  37'({if_valid, if_pc, im_addr}), 37'({1'b1, 5'd5, 5'd5}));
        if_ready = 1'b1;
        tick();
        chk("halt_drain", 37'({if_valid, halted}), 37'(2'b01));

        // Restart from pc 0, then redirect to 12 while pc 1 is pending.
        push(5'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_busy", 37'({busy, halted, im_addr}), 37'({1'b1, 1'b0, 5'd0}));
        tick();
        chk("restart_pc0", 37'(if_pc), 37'(5'd0));
        tick();
        chk("restart_pc1", 37'({if_valid, if_pc}), 37'({1'b1, 5'd1}));
        push(5'd12);
        br_valid = 1'b1; br_target = 5'd12; if_ready = 1'b0;
        tick();
        br_valid = 1'b0; if_ready = 1'b1;
        chk("br_bubble", 37'({if_valid, im_addr}), 37'({1'b0, 5'd12}));
        tick();
        chk("br_first", 37'({if_valid, if_pc, if_instr}), {1'b1, 5'd12, 32'hA000_000C} & 37'h1F_FFFF_FFFF);
        tick();
        chk("br_next", 37'(if_pc), 37'(5'd13));

        // Redirect to 31 and wrap to 0.
        push(5'd31);
        br_valid = 1'b1; br_target = 5'd31;
        tick();
        br_valid = 1'b0;
        chk("wrap_bubble", 37'({if_valid, busy}), 37'(2'b01));
        tick();
        chk("wrap_31", 37'({if_pc, im_addr, busy}), 37'({5'd31, 5'd0, 1'b1}));
        tick();
        if_ready = 1'b0;
        chk("wrap_0", 37'({if_pc, if_instr, busy}), {5'd0, 32'h1111_1111, 1'b1} >> 0);
`ifdef FETCH_PERF_CNT_EN
        chk("flush_cnt", 37'(flush_cnt), 37'(16'd2));
`endif

        // Async reset in the middle of a stall.
        tick();
        chk("pre_rst_valid", 37'(if_valid), 37'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", 37'({if_valid, im_addr, busy, halted}), 37'({1'b0, 5'd0, 1'b0, 1'b0}));
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("post_rst_idle", 37'({if_valid, im_addr, busy}), 37'({1'b0, 5'd0, 1'b0}));
        chk("queue_empty", 37'(exp_q.size()), 37'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
